packet_injector: RTL and testbench

PACKET_INJECTOR -- requirements
Module: packet_injector

---
 rtl/knock_pkg.sv | 29 ++
 rtl/packet_injector.sv | 117 +++++++++++
 tb/tb_packet_injector.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/knock_pkg.sv
`default_nettype none
// knock_pkg: flit/address types, header field positions and injector FSM states
// shared by the packet injector and anything that builds or parses its flits.
package knock_pkg;

  typedef logic [15:0] flit_t;
  typedef logic [7:0]  node_addr_t;

  localparam int unsigned FLIT_LEN_MSB  = 15;
  localparam int unsigned FLIT_LEN_LSB  = 8;
  localparam int unsigned FLIT_ADDR_MSB = 7;
  localparam int unsigned FLIT_ADDR_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } inj_state_e;

  function automatic flit_t make_header(input logic [7:0] len, input node_addr_t dest);
    flit_t hdr;
    hdr = '0;
    hdr[FLIT_LEN_MSB:FLIT_LEN_LSB]   = len;
    hdr[FLIT_ADDR_MSB:FLIT_ADDR_LSB] = dest;
    return hdr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/packet_injector.sv
`default_nettype none
// packet_injector: turns a {dest, len} descriptor plus host payload into a header
// flit and len payload flits for a router local port. INJECTOR_STATS_EN adds counters.
module packet_injector
  import knock_pkg::*;
#(
  parameter int unsigned MAX_LEN    = 15,
  parameter int unsigned LOCAL_ADDR = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_dest,
  input  logic [7:0]  req_len,
  input  logic        pay_valid,
  output logic        pay_ready,
  input  logic [15:0] pay_data,
  input  logic        buffer_full,
  output logic        sending_data,
  output logic [15:0] data_out,
  output logic        pkt_done,
  output logic        req_err
`ifdef INJECTOR_STATS_EN
  ,
  output logic [15:0] pkt_count,
  output logic [15:0] stall_count
`endif
);

  localparam logic [7:0] c_MAX_LEN = 8'(MAX_LEN);

  // Local-addressed packets need no special handling; only the ranges are checked.
  if (MAX_LEN < 1 || MAX_LEN > 255 || LOCAL_ADDR > 255) begin : g_bad_params
    $error("packet_injector: MAX_LEN must be 1..255 and LOCAL_ADDR must fit 8 bits");
  end

  inj_state_e state_q;
  logic [7:0] rem_q;
  flit_t      hdr_q;
  logic       req_err_q;

  logic w_in_hdr;
  logic w_in_pay;

  assign w_in_hdr     = (state_q == ST_HEADER);
  assign w_in_pay     = (state_q == ST_PAYLOAD);
  assign req_ready    = (state_q == ST_IDLE);
  assign pay_ready    = w_in_pay && !buffer_full;
  assign sending_data = (w_in_hdr || (w_in_pay && pay_valid)) && !buffer_full;
  assign data_out     = !sending_data ? 16'h0000 : (w_in_hdr ? hdr_q : pay_data);
  assign pkt_done     = sending_data && (w_in_hdr ? (rem_q == 8'd0) : (rem_q == 8'd1));
  assign req_err      = req_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      rem_q     <= 8'd0;
      hdr_q     <= '0;
      req_err_q <= 1'b0;
    end else begin
      req_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_len <= c_MAX_LEN) begin
              hdr_q   <= make_header(req_len, req_dest);
              rem_q   <= req_len;
              state_q <= ST_HEADER;
            end else begin
              req_err_q <= 1'b1;
            end
          end
        end
        ST_HEADER: begin
          if (!buffer_full) begin
            state_q <= (rem_q == 8'd0) ? ST_IDLE : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (sending_data) begin
            rem_q <= rem_q - 8'd1;
            if (rem_q == 8'd1) begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef INJECTOR_STATS_EN
  logic [15:0] pkt_cnt_q;
  logic [15:0] stall_cnt_q;

  // Both counters wrap naturally at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt_q   <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      if (pkt_done) begin
        pkt_cnt_q <= pkt_cnt_q + 16'd1;
      end
      if (!req_ready && buffer_full) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign pkt_count   = pkt_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_packet_injector.sv
`default_nettype none
// tb_packet_injector: directed stimulus with a flit-stream model checked every cycle.
module tb_packet_injector;

  localparam int MAX_LEN = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_dest = 8'h00;
  logic [7:0]  req_len = 8'h00;
  logic        pay_valid = 1'b0;
  logic        pay_ready;
  logic [15:0] pay_data = 16'h0000;
  logic        buffer_full = 1'b0;
  logic        sending_data;
  logic [15:0] data_out;
  logic        pkt_done;
  logic        req_err;
`ifdef INJECTOR_STATS_EN
  logic [15:0] pkt_count;
  logic [15:0] stall_count;
`endif

  packet_injector #(.MAX_LEN(MAX_LEN), .LOCAL_ADDR(8'h00)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dest(req_dest), .req_len(req_len),
    .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data),
    .buffer_full(buffer_full),
    .sending_data(sending_data), .data_out(data_out),
    .pkt_done(pkt_done), .req_err(req_err)
`ifdef INJECTOR_STATS_EN
    , .pkt_count(pkt_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] f; bit last; bit hdr; } exp_t;
  typedef struct { logic [15:0] f; bit done; int cyc; } log_t;

  exp_t        exp_q[$];
  log_t        sent_log[$];
  logic [15:0] pay_src[$];
  logic [15:0] model_pay[$];
  int          hs_cyc[$];

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  int  hs_cnt  = 0;
  int  err_cnt = 0;
  bit  err_pend = 0;
  bit  pay_took = 0;
  bit  bubble_en = 0;
  bit  bub_tog = 0;
  int  m_pkts = 0;
  int  m_stalls = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Host payload source: presents the head of pay_src, optionally every other cycle.
  always begin
    @(posedge clk);
    #1;
    if (pay_took && pay_src.size() > 0) void'(pay_src.pop_front());
    bub_tog = ~bub_tog;
    pay_valid = (pay_src.size() > 0) && (!bubble_en || bub_tog);
    pay_data  = pay_valid ? pay_src[0] : 16'hDEAD;
  end

  // Model and per-cycle compare, sampled mid-cycle.
  always @(negedge clk) begin
    bit   exp_send;
    bit   exp_pr;
    exp_t e;
    cyc++;
    if (!rst) begin
      check("rst_sending", {31'd0, sending_data}, 32'd0);
      check("rst_pay_ready", {31'd0, pay_ready}, 32'd0);
      check("rst_pkt_done", {31'd0, pkt_done}, 32'd0);
      check("rst_req_err", {31'd0, req_err}, 32'd0);
      exp_q.delete();
      err_pend = 0;
      pay_took = 0;
      m_pkts = 0;
      m_stalls = 0;
    end else begin
      exp_send = (exp_q.size() > 0) && !buffer_full && (exp_q[0].hdr || pay_valid);
      exp_pr   = (exp_q.size() > 0) && !exp_q[0].hdr && !buffer_full;
      check("sending_data", {31'd0, sending_data}, {31'd0, exp_send});
      check("pay_ready", {31'd0, pay_ready}, {31'd0, exp_pr});
      check("req_ready", {31'd0, req_ready}, {31'd0, exp_q.size() == 0});
      check("req_err", {31'd0, req_err}, {31'd0, err_pend});
`ifdef INJECTOR_STATS_EN
      check("pkt_count", {16'd0, pkt_count}, 32'(m_pkts[15:0]));
      check("stall_count", {16'd0, stall_count}, 32'(m_stalls[15:0]));
`endif
      if (exp_q.size() > 0 && buffer_full) m_stalls++;
      if (sending_data) begin
        sent_log.push_back('{data_out, pkt_done, cyc});
        if (exp_q.size() == 0) begin
          check("unexpected_flit", {16'd0, data_out}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("data_out", {16'd0, data_out}, {16'd0, e.f});
          check("pkt_done", {31'd0, pkt_done}, {31'd0, e.last});
          if (e.last) m_pkts++;
        end
      end else begin
        check("idle_data_out", {16'd0, data_out}, 32'd0);
        check("idle_pkt_done", {31'd0, pkt_done}, 32'd0);
      end
      pay_took = pay_valid && pay_ready;
      err_pend = 0;
      if (req_valid && req_ready) begin
        hs_cnt++;
        hs_cyc.push_back(cyc);
        if (req_len > MAX_LEN) begin
          err_pend = 1;
          err_cnt++;
        end else begin
          exp_q.push_back('{{req_len, req_dest}, req_len == 0, 1'b1});
          for (int i = 0; i < int'(req_len); i++) begin
            logic [15:0] w;
            w = (model_pay.size() > 0) ? model_pay.pop_front() : 16'hBAD0;
            exp_q.push_back('{w, i == int'(req_len) - 1, 1'b0});
          end
        end
      end
    end
  end

  task automatic send_req(input logic [7:0] dest, input logic [7:0] len);
    int start;
    int k;
    start = hs_cnt;
    k = 0;
    req_dest = dest;
    req_len = len;
    req_valid = 1'b1;
    while (hs_cnt == start && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    req_valid = 1'b0;
    if (hs_cnt == start) check("req_handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_log(input int n);
    int k;
    k = 0;
    while (sent_log.size() < n && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (sent_log.size() < n) check("wait_log_timeout", sent_log.size(), n);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || !req_ready) && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 100) check("wait_idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int base;
    int e0;
`ifdef INJECTOR_STATS_EN
    int sc0;
    int pc0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_sending", {31'd0, sending_data}, 32'd0);
    @(posedge clk);
    #1;

    // Basic 3-flit packet.
    pay_src = '{16'h00A1, 16'h00A2, 16'h00A3};
    model_pay = '{16'h00A1, 16'h00A2, 16'h00A3};
    base = sent_log.size();
    send_req(8'h21, 8'd3);
    wait_idle();
    check("t1_count", sent_log.size() - base, 32'd4);
    if (sent_log.size() - base == 4) begin
      check("t1_hdr", {16'd0, sent_log[base].f}, 32'h0321);
      check("t1_p3", {16'd0, sent_log[base+3].f}, 32'h00A3);
      check("t1_done_last", {31'd0, sent_log[base+3].done}, 32'd1);
      check("t1_done_early", {31'd0, sent_log[base+2].done}, 32'd0);
      check("t1_consecutive", sent_log[base+3].cyc - sent_log[base].cyc, 32'd3);
    end

    // Zero-length packet.
    base = sent_log.size();
    send_req(8'h10, 8'd0);
    wait_log(base + 1);
    check("t2_hdr", {16'd0, sent_log[base].f}, 32'h0010);
    check("t2_done", {31'd0, sent_log[base].done}, 32'd1);
    @(negedge clk);
    check("t2_req_ready_after", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Five-cycle backpressure right after the header.
    pay_src = '{16'h00B1, 16'h00B2};
    model_pay = '{16'h00B1, 16'h00B2};
    base = sent_log.size();
`ifdef INJECTOR_STATS_EN
    sc0 = int'(stall_count);
`endif
    send_req(8'h32, 8'd2);
    wait_log(base + 1);
    buffer_full = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    buffer_full = 1'b0;
    wait_idle();
    check("t3_count", sent_log.size() - base, 32'd3);
    if (sent_log.size() - base == 3) begin
      check("t3_hdr", {16'd0, sent_log[base].f}, 32'h0232);
      check("t3_b1", {16'd0, sent_log[base+1].f}, 32'h00B1);
      check("t3_b2", {16'd0, sent_log[base+2].f}, 32'h00B2);
      check("t3_stall_gap", sent_log[base+1].cyc - sent_log[base].cyc, 32'd6);
    end
`ifdef INJECTOR_STATS_EN
    check("t3_stall_count", int'(stall_count) - sc0, 32'd5);
`endif

    // Oversized descriptor is rejected.
    base = sent_log.size();
    e0 = err_cnt;
    send_req(8'h55, 8'd16);
    @(negedge clk);
    check("t4_req_err_pulse", {31'd0, req_err}, 32'd1);
    check("t4_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t4_err_count", err_cnt - e0, 32'd1);
    check("t4_no_send", sent_log.size() - base, 32'd0);

    // Reset in the middle of a 4-flit packet.
    pay_src = '{16'h00C1, 16'h00C2, 16'h00C3, 16'h00C4};
    model_pay = '{16'h00C1, 16'h00C2, 16'h00C3, 16'h00C4};
    base = sent_log.size();
    send_req(8'h44, 8'd4);
    wait_log(base + 2);
    rst = 1'b0;
    #1;
    check("t5_rst_sending", {31'd0, sending_data}, 32'd0);
    check("t5_rst_data_out", {16'd0, data_out}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    pay_src.delete();
    model_pay.delete();
    rst = 1'b1;
    @(negedge clk);
    check("t5_req_ready_after", {31'd0, req_ready}, 32'd1);
    check("t5_abandoned", sent_log.size() - base, 32'd2);
    @(posedge clk);
    #1;
    pay_src = '{16'h00D1};
    model_pay = '{16'h00D1};
    base = sent_log.size();
    send_req(8'h00, 8'd1);
    wait_idle();
    check("t5_new_count", sent_log.size() - base, 32'd2);
    if (sent_log.size() - base == 2) begin
      check("t5_local_hdr", {16'd0, sent_log[base].f}, 32'h0100);
      check("t5_d1", {16'd0, sent_log[base+1].f}, 32'h00D1);
    end

    // Back-to-back single-flit packets with payload bubbles.
    bubble_en = 1'b1;
    pay_src = '{16'h00E1, 16'h00E2};
    model_pay = '{16'h00E1, 16'h00E2};
    base = sent_log.size();
`ifdef INJECTOR_STATS_EN
    pc0 = int'(pkt_count);
`endif
    send_req(8'h12, 8'd1);
    send_req(8'h13, 8'd1);
    wait_idle();
    bubble_en = 1'b0;
    check("t6_count", sent_log.size() - base, 32'd4);
    if (sent_log.size() - base == 4 && hs_cyc.size() >= 2) begin
      check("t6_e1", {16'd0, sent_log[base+1].f}, 32'h00E1);
      check("t6_hdr2", {16'd0, sent_log[base+2].f}, 32'h0113);
      check("t6_one_idle_gap", hs_cyc[hs_cyc.size()-1] - sent_log[base+1].cyc, 32'd1);
    end
`ifdef INJECTOR_STATS_EN
    check("t6_pkt_count", int'(pkt_count) - pc0, 32'd2);
`endif

    repeat (3) @(posedge clk);
    check("all_flits_sent", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
